// File: rtl/pipe_field.sv
// pipe_field: scrolling pipe-column engine for the Flappy Bird playfield.
// Generates NUM_PIPES columns with LFSR-randomised gaps and scrolls them
// leftwards on a divided tick while the play state machine is in RUN.
// Reports pixel coverage, bird collision and score pulses.
// Optional difficulty ramp: define PIPE_FIELD_RAMP_EN to enable the
// pass counter, level output, faster scrolling and narrowing gaps.
module pipe_field #(
    parameter int NUM_PIPES      = 4,
    parameter int PIPE_WIDTH     = 40,
    parameter int PIPE_SPACING   = 220,
    parameter int SCREEN_WIDTH   = 800,
    parameter int SPAWN_OFFSET   = 80,
    parameter int TICK_DIV       = 1_000_000,
    parameter int GAP_MIN_TOP    = 60,
    parameter int GAP_MAX_TOP    = 320,
    parameter int GAP_SIZE_START = 150,
    parameter int GAP_SIZE_MIN   = 90,
    parameter int RAMP_EVERY     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic       restart,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic [9:0] bird_x,
    input  logic [9:0] bird_y,
    input  logic [4:0] bird_w,
    input  logic [4:0] bird_h,
    output logic       pipe_pixel,
    output logic       pipe_collision,
    output logic       pipe_passed,
    output logic [1:0] level,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FROZEN = 2'b10
    } play_state_t;

    localparam int               RESPAWN_X   = SCREEN_WIDTH + SPAWN_OFFSET;
    localparam logic [10:0]      RESPAWN_X11 = 11'(RESPAWN_X);
    localparam logic [10:0]      WIDTH11     = 11'(PIPE_WIDTH);
    localparam logic [10:0]      SPACING11   = 11'(PIPE_SPACING);
    localparam logic [9:0]       GAP_MIN10   = 10'(GAP_MIN_TOP);
    localparam logic [9:0]       GAP_MAX10   = 10'(GAP_MAX_TOP);
    localparam logic [8:0]       GAP_START9  = 9'(GAP_SIZE_START);
    localparam int               DIV_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);

    // Reject parameter sets the fixed datapath widths cannot represent.
    if (NUM_PIPES < 2 || NUM_PIPES > 8 || RAMP_EVERY < 1 ||
        GAP_SIZE_MIN > GAP_SIZE_START || GAP_MIN_TOP > GAP_MAX_TOP) begin : g_bad_cfg
        $error("pipe_field: unsupported parameter set");
    end

    // Restrict a candidate gap top to the permitted vertical band.
    function automatic logic [9:0] clamp_gap(input logic [9:0] v);
        logic [9:0] r;
        r = v;
        if (v < GAP_MIN10) r = GAP_MIN10;
        else if (v > GAP_MAX10) r = GAP_MAX10;
        return r;
    endfunction

    // Starting column position; columns queue up off-screen to the right.
    function automatic logic [10:0] reset_x(input int i);
        return 11'(RESPAWN_X + i * PIPE_SPACING);
    endfunction

    // Starting gap top: a fixed staircase so the first screen is playable.
    function automatic logic [9:0] reset_gap(input int i);
        return clamp_gap(10'(GAP_MIN_TOP + 60 * i));
    endfunction

    play_state_t          state_q;
    play_state_t          state_next;
    logic [10:0]          x_q        [NUM_PIPES];
    logic [9:0]           gap_top_q  [NUM_PIPES];
    logic [8:0]           gap_size_q [NUM_PIPES];
    logic [9:0]           lfsr_q;
    logic [DIV_W-1:0]     div_q;
    logic                 passed_q;

    logic                 tick;
    logic [10:0]          speed;
    logic [8:0]           gap_now;
    logic [NUM_PIPES-1:0] moving;
    logic [10:0]          x_next     [NUM_PIPES];
    logic [10:0]          best_x;
    logic                 pass_hit;

    logic [10:0]          x_end;
    logic [10:0]          gap_end;
    logic [10:0]          bird_right;
    logic [10:0]          bird_bottom;
    logic                 horiz_hit;

`ifdef PIPE_FIELD_RAMP_EN
    localparam logic [15:0] STEP1 = 16'(RAMP_EVERY);
    localparam logic [15:0] STEP2 = 16'(2 * RAMP_EVERY);
    localparam logic [15:0] STEP3 = 16'(3 * RAMP_EVERY);

    logic [15:0] pass_count_q;

    // Gap height narrows by 20 px per level down to the floor.
    function automatic logic [8:0] gap_for_level(input logic [1:0] lv);
        int g;
        g = GAP_SIZE_START - 20 * int'(lv);
        if (g < GAP_SIZE_MIN) g = GAP_SIZE_MIN;
        return 9'(g);
    endfunction

    assign level   = (pass_count_q >= STEP3) ? 2'd3 :
                     (pass_count_q >= STEP2) ? 2'd2 :
                     (pass_count_q >= STEP1) ? 2'd1 : 2'd0;
    assign gap_now = gap_for_level(level);

    // Saturating count of scoring ticks; drives the difficulty level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_count_q <= '0;
        end else if (restart) begin
            pass_count_q <= '0;
        end else if (tick && pass_hit && (pass_count_q != 16'hFFFF)) begin
            pass_count_q <= pass_count_q + 16'd1;
        end
    end
`else
    assign level   = 2'd0;
    assign gap_now = GAP_START9;
`endif

    assign speed       = 11'd1 + {9'd0, level};
    assign tick        = (state_q == RUN) && enable && !restart && (div_q == DIV_LAST);
    assign pipe_passed = passed_q;
    assign state       = state_q;

    // Play state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_next;
    end

    // Next play state: restart beats collision, collision beats start; enable gates all moves.
    always_comb begin
        state_next = state_q;
        if (restart) begin
            state_next = IDLE;
        end else if (enable) begin
            case (state_q)
                IDLE:    if (start) state_next = RUN;
                RUN:     if (pipe_collision) state_next = FROZEN;
                FROZEN:  state_next = FROZEN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Tick update: move every column, then place respawning columns in index order.
    always_comb begin
        pass_hit = 1'b0;
        best_x   = RESPAWN_X11;
        moving   = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            moving[i] = x_q[i] > speed;
            x_next[i] = moving[i] ? (x_q[i] - speed) : x_q[i];
            if (moving[i] && ((x_q[i] + WIDTH11) > {1'b0, bird_x}) &&
                ((x_next[i] + WIDTH11) <= {1'b0, bird_x})) begin
                pass_hit = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (!moving[i]) begin
                best_x = RESPAWN_X11;
                for (int j = 0; j < NUM_PIPES; j++) begin
                    if ((j != i) && ((x_next[j] + SPACING11) > best_x)) begin
                        best_x = x_next[j] + SPACING11;
                    end
                end
                x_next[i] = best_x;
            end
        end
    end

    // Column state, LFSR, tick divider and score pulse; restart mirrors reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i]        <= reset_x(i);
                gap_top_q[i]  <= reset_gap(i);
                gap_size_q[i] <= GAP_START9;
            end
            lfsr_q   <= 10'h3FF;
            div_q    <= '0;
            passed_q <= 1'b0;
        end else if (restart) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i]        <= reset_x(i);
                gap_top_q[i]  <= reset_gap(i);
                gap_size_q[i] <= GAP_START9;
            end
            lfsr_q   <= 10'h3FF;
            div_q    <= '0;
            passed_q <= 1'b0;
        end else begin
            passed_q <= 1'b0;
            if (enable && (state_q == RUN)) begin
                div_q <= tick ? '0 : (div_q + 1'b1);
                if (tick) begin
                    lfsr_q   <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
                    passed_q <= pass_hit;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        x_q[i] <= x_next[i];
                        if (!moving[i]) begin
                            gap_top_q[i]  <= clamp_gap(lfsr_q ^ 10'(i * 10'h0F5));
                            gap_size_q[i] <= gap_now;
                        end
                    end
                end
            end
        end
    end

    // Pixel coverage and bird overlap against every column body.
    always_comb begin
        pipe_pixel     = 1'b0;
        pipe_collision = 1'b0;
        x_end          = '0;
        gap_end        = '0;
        horiz_hit      = 1'b0;
        bird_right     = {1'b0, bird_x} + {6'd0, bird_w};
        bird_bottom    = {1'b0, bird_y} + {6'd0, bird_h};
        for (int i = 0; i < NUM_PIPES; i++) begin
            x_end   = x_q[i] + WIDTH11;
            gap_end = {1'b0, gap_top_q[i]} + {2'd0, gap_size_q[i]};
            if (({1'b0, hCount} >= x_q[i]) && ({1'b0, hCount} < x_end) &&
                !(({1'b0, vCount} >= {1'b0, gap_top_q[i]}) && ({1'b0, vCount} < gap_end))) begin
                pipe_pixel = 1'b1;
            end
            horiz_hit = (bird_right > x_q[i]) && ({1'b0, bird_x} < x_end);
            if (horiz_hit && (({1'b0, bird_y} < {1'b0, gap_top_q[i]}) || (bird_bottom > gap_end))) begin
                pipe_collision = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_field.sv
// tb_pipe_field: directed self-checking bench for pipe_field.
// Column positions and gaps are observed through pipe_pixel probes.
module tb_pipe_field;

`ifdef PIPE_FIELD_RAMP_EN
    localparam int EXP_LEVEL     = 1;
    localparam int EXP_GAP       = 130;
    localparam int PIPE1_RESPAWN = 1070;
`else
    localparam int EXP_LEVEL     = 0;
    localparam int EXP_GAP       = 150;
    localparam int PIPE1_RESPAWN = 1100;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, start, restart;
    logic [9:0] hCount, vCount, bird_x, bird_y;
    logic [4:0] bird_w, bird_h;
    logic       pipe_pixel, pipe_collision, pipe_passed;
    logic [1:0] level, state;

    int tests_run    = 0;
    int tests_failed = 0;

    pipe_field #(
        .NUM_PIPES (4),
        .TICK_DIV  (4),
        .RAMP_EVERY(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .start         (start),
        .restart       (restart),
        .hCount        (hCount),
        .vCount        (vCount),
        .bird_x        (bird_x),
        .bird_y        (bird_y),
        .bird_w        (bird_w),
        .bird_h        (bird_h),
        .pipe_pixel    (pipe_pixel),
        .pipe_collision(pipe_collision),
        .pipe_passed   (pipe_passed),
        .level         (level),
        .state         (state)
    );

    // Free-running clock, 100 time units per period.
    always #50 clk = ~clk;

    task automatic probe(input logic [9:0] h, input logic [9:0] v, output logic p);
        hCount = h;
        vCount = v;
        #1;
        p = pipe_pixel;
    endtask

    // Returns {pixel at xe-1, pixel at xe} on a row outside every gap.
    task automatic edge_at(input logic [9:0] xe, output logic [1:0] got);
        logic a, b;
        probe(xe - 10'd1, 10'd0, a);
        probe(xe, 10'd0, b);
        got = {a, b};
    endtask

    task automatic scan_gap(input logic [9:0] h, output int top, output int size);
        logic p;
        top  = -1;
        size = 0;
        for (int v = 0; v < 512; v++) begin
            probe(h, 10'(v), p);
            if (!p) begin
                if (size == 0) top = v;
                size++;
            end
        end
    endtask

    task automatic run_ticks(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [1:0] e;
        logic       p;
        reset = 1'b1; enable = 1'b1; start = 1'b0; restart = 1'b0;
        bird_x = 10'd100; bird_y = 10'd130; bird_w = 5'd10; bird_h = 5'd10;
        hCount = 10'd0; vCount = 10'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_state: got %b, expected 00", state); end
        tests_run++;
        if (level !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_level: got %0d, expected 0", level); end
        tests_run++;
        if (pipe_passed !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_passed: got %b, expected 0", pipe_passed); end
        tests_run++;
        if (pipe_collision !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_collision: got %b, expected 0", pipe_collision); end
        tests_run++;
        if (pipe_pixel !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pixel_origin: got %b, expected 0", pipe_pixel); end
        edge_at(10'd880, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL reset_pipe0_left: got %b, expected 01", e); end
        edge_at(10'd920, e);
        tests_run++;
        if (e !== 2'b10) begin tests_failed++; $display("[TB] FAIL reset_pipe0_right: got %b, expected 10", e); end
        probe(10'd890, 10'd59, p);
        tests_run++;
        if (p !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_above_gap: got %b, expected 1", p); end
        probe(10'd890, 10'd60, p);
        tests_run++;
        if (p !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_gap_top: got %b, expected 0", p); end
        probe(10'd890, 10'd209, p);
        tests_run++;
        if (p !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_gap_last: got %b, expected 0", p); end
        probe(10'd890, 10'd210, p);
        tests_run++;
        if (p !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_below_gap: got %b, expected 1", p); end
    endtask

    task automatic test_start_tick();
        logic [1:0] e;
        int         xe;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        tests_run++;
        if (state !== 2'b01) begin tests_failed++; $display("[TB] FAIL start_state: got %b, expected 01", state); end
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            xe = 880 - c / 4;
            edge_at(10'(xe), e);
            tests_run++;
            if (e !== 2'b01) begin
                tests_failed++;
                $display("[TB] FAIL tick_cadence clk %0d: edge pattern %b at x=%0d, expected 01", c, e, xe);
            end
        end
        edge_at(10'd876, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL four_ticks_x876: got %b, expected 01", e); end
    endtask

    task automatic test_pass();
        run_ticks(815);
        #1;
        tests_run++;
        if (pipe_passed !== 1'b0) begin tests_failed++; $display("[TB] FAIL pass_before: got %b, expected 0", pipe_passed); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (pipe_passed !== (k == 3)) begin
                tests_failed++;
                $display("[TB] FAIL pass_pulse clk %0d: got %b, expected %b", k, pipe_passed, (k == 3));
            end
        end
        tests_run++;
        if (level !== 2'd0) begin tests_failed++; $display("[TB] FAIL pass_level: got %0d, expected 0", level); end
        tests_run++;
        if (state !== 2'b01) begin tests_failed++; $display("[TB] FAIL pass_still_run: got %b, expected 01", state); end
    endtask

    task automatic test_respawn();
        logic [1:0] e;
        int         top, size;
        run_ticks(58);
        edge_at(10'd1, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL pipe0_at_1: got %b, expected 01", e); end
        run_ticks(1);
        edge_at(10'd880, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL respawn_x880: got %b, expected 01", e); end
        edge_at(10'd660, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL pipe3_x660: got %b, expected 01", e); end
        enable = 1'b0;
        repeat (7) @(negedge clk);
        edge_at(10'd880, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL pause_hold_x: got %b, expected 01", e); end
        scan_gap(10'd890, top, size);
        tests_run++;
        if (top < 60 || top > 320) begin tests_failed++; $display("[TB] FAIL respawn_gap_top: got %0d, expected 60..320", top); end
        tests_run++;
        if (size !== 150) begin tests_failed++; $display("[TB] FAIL respawn_gap_size: got %0d, expected 150", size); end
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        edge_at(10'd880, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL divider_hold_pre: got %b, expected 01", e); end
        @(negedge clk);
        edge_at(10'd879, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL divider_hold_tick: got %b, expected 01", e); end
    endtask

    task automatic test_ramp();
        logic [1:0] e;
        int         top, size;
        run_ticks(158);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (pipe_passed !== (k == 3)) begin
                tests_failed++;
                $display("[TB] FAIL second_pass clk %0d: got %b, expected %b", k, pipe_passed, (k == 3));
            end
        end
        tests_run++;
        if (level !== 2'(EXP_LEVEL)) begin tests_failed++; $display("[TB] FAIL ramp_level: got %0d, expected %0d", level, EXP_LEVEL); end
        run_ticks(PIPE1_RESPAWN - 1040);
        edge_at(10'd880, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL pipe1_respawn_x880: got %b, expected 01", e); end
        edge_at(10'd660, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL pipe0_x660: got %b, expected 01", e); end
        enable = 1'b0;
        scan_gap(10'd890, top, size);
        tests_run++;
        if (size !== EXP_GAP) begin tests_failed++; $display("[TB] FAIL ramp_gap_size: got %0d, expected %0d", size, EXP_GAP); end
        tests_run++;
        if (top < 60 || top > 320) begin tests_failed++; $display("[TB] FAIL ramp_gap_top: got %0d, expected 60..320", top); end
    endtask

    task automatic test_collision();
        logic [1:0] e;
        @(negedge clk);
        enable = 1'b1;
        bird_x = 10'd230; bird_y = 10'd50;
        #1;
        tests_run++;
        if (pipe_collision !== 1'b1) begin tests_failed++; $display("[TB] FAIL collision_comb: got %b, expected 1", pipe_collision); end
        tests_run++;
        if (state !== 2'b01) begin tests_failed++; $display("[TB] FAIL collision_same_cycle_state: got %b, expected 01", state); end
        @(negedge clk);
        #1;
        tests_run++;
        if (state !== 2'b10) begin tests_failed++; $display("[TB] FAIL frozen_state: got %b, expected 10", state); end
        repeat (12) @(negedge clk);
        edge_at(10'd220, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL frozen_x220: got %b, expected 01", e); end
        tests_run++;
        if (state !== 2'b10) begin tests_failed++; $display("[TB] FAIL frozen_hold: got %b, expected 10", state); end
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        #1;
        tests_run++;
        if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL restart_state: got %b, expected 00", state); end
        tests_run++;
        if (level !== 2'd0) begin tests_failed++; $display("[TB] FAIL restart_level: got %0d, expected 0", level); end
        tests_run++;
        if (pipe_collision !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_collision: got %b, expected 0", pipe_collision); end
        edge_at(10'd880, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL restart_x880: got %b, expected 01", e); end
    endtask

    task automatic test_async_reset();
        logic [1:0] e;
        bird_x = 10'd100; bird_y = 10'd130;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        edge_at(10'd879, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL rerun_x879: got %b, expected 01", e); end
        #20;
        reset = 1'b1;
        #1;
        tests_run++;
        if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL async_reset_state: got %b, expected 00", state); end
        edge_at(10'd880, e);
        tests_run++;
        if (e !== 2'b01) begin tests_failed++; $display("[TB] FAIL async_reset_x880: got %b, expected 01", e); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_tick();
        test_pass();
        test_respawn();
        test_ramp();
        test_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_field.md
# pipe_field

Parametrised pipe-column engine for the Flappy Bird playfield. It generates and scrolls a configurable number of pipe columns with LFSR-randomised gaps, and runs an IDLE/RUN/FROZEN play state machine. It also provides an optional difficulty ramp that speeds up scrolling and narrows gaps as the score grows. It sits between the game controller (start/restart, bird position) and the VGA pixel mux (pipe_pixel), and feeds scoring (pipe_passed) and game-over (pipe_collision).

## Interface
- NUM_PIPES, 4, pipe columns, 2..8
- PIPE_WIDTH, 40, column width in pixels
- PIPE_SPACING, 220, horizontal distance between consecutive columns
- SCREEN_WIDTH, 800, visible width
- SPAWN_OFFSET, 80, off-screen spawn margin; RESPAWN_X = SCREEN_WIDTH + SPAWN_OFFSET
- TICK_DIV, 1_000_000, clk cycles per scroll tick
- GAP_MIN_TOP, 60, lowest permitted gap top
- GAP_MAX_TOP, 320, highest permitted gap top
- GAP_SIZE_START, 150, gap height at level 0
- GAP_SIZE_MIN, 90, gap height floor
- RAMP_EVERY, 8, passes per level step
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  global pause; low freezes all sequential state except pipe_passed, which is forced to 0
- start  in  1  IDLE→RUN request, level-sampled
- restart  in  1  synchronous return to reset state
- hCount, vCount  in  10 each  current VGA pixel
- bird_x, bird_y  in  10 each  bird top-left
- bird_w, bird_h  in  5 each  bird size
- pipe_pixel  out  1  current pixel lies on any pipe body
- pipe_collision  out  1  bird box overlaps any pipe body
- pipe_passed  out  1  one-cycle score pulse
- level  out  2  current difficulty level, 0..3
- state  out  2  00 IDLE, 01 RUN, 10 FROZEN

## Operation
- Per pipe i: x[i] is 11 bits, gap_top[i] is 10 bits, gap_size[i] is 9 bits.
- Reset/restart values:
  - x[i] = RESPAWN_X + i·PIPE_SPACING
  - gap_top[i] = clamp(GAP_MIN_TOP + 60·i)
  - gap_size[i] = GAP_SIZE_START
  - LFSR = 10'h3FF, divider = 0, pass count = 0, level = 0, state = IDLE, pipe_passed = 0
- States:
  - IDLE: pipes static. Goes to RUN on start & enable.
  - RUN: scrolling. Goes to FROZEN on pipe_collision & enable.
  - FROZEN: pipes static, outputs still drawn. Goes to IDLE on restart.
  - Priority: restart > collision > start.
- Tick: in RUN with enable, divider counts to TICK_DIV-1, then wraps to 0 and issues one tick. On each tick:
  - LFSR shifts left; feedback = b9^b6 (x^10+x^7+1).
  - speed = 1 + level.
  - Pipe i with x[i] > speed: x[i] -= speed.
    - Pass event when x[i]+PIPE_WIDTH > bird_x before the move and ≤ bird_x after it.
  - Pipe i with x[i] ≤ speed: respawns.
    - x[i] = max(RESPAWN_X, max over j≠i of x[j] + PIPE_SPACING).
    - Lower-index respawns resolve first; a higher-index respawn sees their new x.
    - gap_top[i] = clamp(LFSR ^ (i·10'h0F5)) to [GAP_MIN_TOP, GAP_MAX_TOP].
    - gap_size[i] = current gap size.
  - Multiple pass events in one tick produce one pipe_passed pulse and increment the pass count by 1.
- pipe_pixel:
  - hCount in [x, x+PIPE_WIDTH)
  - and vCount not in [gap_top, gap_top+gap_size).
- pipe_collision:
  - Horizontal overlap: bird_x+bird_w > x and bird_x < x+PIPE_WIDTH.
  - And vertical miss: bird_y < gap_top or bird_y+bird_h > gap_top+gap_size.
- Arithmetic:
  - All comparisons are 11-bit unsigned, zero-extended.
  - The pass count saturates at its maximum.

## Timing
- pipe_pixel and pipe_collision are combinational from registered state and inputs; zero latency.
- pipe_passed is registered: high exactly the cycle after the tick edge, then 0.
- A new speed applies from the tick after the level change.
- A new gap size applies only to pipes respawned after the level change.
- The RUN→FROZEN edge takes effect on the clock after collision is sampled; no tick occurs in FROZEN.
- Asynchronous reset mid-tick returns all state to the reset values immediately.

## Configuration
- PIPE_FIELD_RAMP_EN defined:
  - level = min(3, pass_count / RAMP_EVERY).
  - gap size = max(GAP_SIZE_MIN, GAP_SIZE_START − 20·level).
- Undefined:
  - level is tied to 0.
  - speed is fixed at 1.
  - gap size is fixed at GAP_SIZE_START.
  - The pass counter is not implemented.

## Test plan
- Reset with TICK_DIV=4, NUM_PIPES=4 -> x = 880/1100/1320/1540; state=00; all outputs 0.
- start=1 for one cycle; run 4 ticks -> state=01, pipe0 x=876; a tick pulse occurs every 4 clocks.
- bird_x=100; pipe0 scrolls from x=61 to x=60 -> pipe_passed high for exactly 1 cycle; no pulse on the next tick.
- Bird at a pipe column, bird_y < gap_top -> pipe_collision=1 the same cycle; state=10 next cycle; x frozen; restart -> IDLE with reset positions.
- RAMP_EN defined, RAMP_EVERY=2, 2 passes -> level=1, speed 2 px/tick, next respawned gap_size=130; with macro undefined -> level=0, gap_size=150.
- x[0]=1 at a tick -> pipe0 respawns at max(880, max others + 220), gap_top within [60, 320]; enable=0 mid-run -> divider and x hold.
